// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select codes,
// dmem-wait FSM states and the forwarding priority helper.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } hz_state_e;

  // The M-stage result is younger than W, so it wins when both match.
  function automatic fwd_e fwd_pick(input logic hit_m, input logic hit_w);
    fwd_e sel;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard unit performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] MAX_Q = '1;

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (inc && (r_q != MAX_Q)) begin
      r_q <= r_q + CNT_W'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RISC-V pipe: forwarding, load-use / RAW stalls,
// branch flush, dmem wait with timeout, and saturating perf counters.
module hazard_unit_mc
  import riscv_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int FWD_EN   = 1,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcEb0,
  input  logic              PCSrcE,
  input  logic              DmemReqM,
  input  logic              DmemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              BusErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic [CNT_W-1:0]  LdUseCnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [REG_AW-1:0] X0 = '0;

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_bus_err;
  logic              w_bus_err_nxt;

  logic w_fwd_en;
  logic w_lw;
  logic w_raw1;
  logic w_raw2;
  logic w_raw;
  logic w_ld_stall;
  logic w_req_wait;
  logic w_dw;
  logic w_stall_any;
  logic w_flush_br;

  assign w_fwd_en = (FWD_EN != 0);

  assign ForwardAE = w_fwd_en ?
      fwd_pick(RegWriteM && (RdM != X0) && (RdM == Rs1E),
               RegWriteW && (RdW != X0) && (RdW == Rs1E)) : FWD_NONE;
  assign ForwardBE = w_fwd_en ?
      fwd_pick(RegWriteM && (RdM != X0) && (RdM == Rs2E),
               RegWriteW && (RdW != X0) && (RdW == Rs2E)) : FWD_NONE;

  assign w_lw = ResultSrcEb0 && (RdE != X0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Without forwarding, any in-flight E/M writer of a D source must be waited out.
  assign w_raw1 = (Rs1D != X0) &&
                  ((RegWriteE && (RdE == Rs1D)) || (RegWriteM && (RdM == Rs1D)));
  assign w_raw2 = (Rs2D != X0) &&
                  ((RegWriteE && (RdE == Rs2D)) || (RegWriteM && (RdM == Rs2D)));
  assign w_raw  = !w_fwd_en && (w_raw1 || w_raw2);

  assign w_ld_stall = w_lw || w_raw;
  assign w_req_wait = DmemReqM && !DmemReadyM;
  assign w_dw       = w_req_wait || (r_state == ERR);

  // A dmem wait freezes the whole front of the pipe, so a pending flush is held off.
  assign StallF = w_ld_stall || w_dw;
  assign StallD = w_ld_stall || w_dw;
  assign StallE = w_dw;
  assign StallM = w_dw;
  assign FlushW = w_dw;
  assign FlushD = PCSrcE && !w_dw;
  assign FlushE = (PCSrcE || w_ld_stall) && !w_dw;
  assign BusErr = r_bus_err;

  assign w_stall_any = StallF || StallD || StallE || StallM;
  assign w_flush_br  = PCSrcE && !w_dw;

  // FSM state, wait counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_bus_err  <= w_bus_err_nxt;
    end
  end

  // Next-state logic: ERR is reached after MAX_WAIT consecutive not-ready cycles.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_bus_err_nxt  = r_bus_err;
    case (r_state)
      IDLE: begin
        if (w_req_wait) begin
          w_wait_cnt_nxt = WAIT_W'(1);
          if (MAX_WAIT == 1) begin
            w_state_nxt   = ERR;
            w_bus_err_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end else begin
          w_wait_cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (!w_req_wait) begin
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
          w_state_nxt    = ERR;
          w_wait_cnt_nxt = WAIT_W'(MAX_WAIT);
          w_bus_err_nxt  = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ERR: begin
        w_state_nxt   = ERR;
        w_bus_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
        w_bus_err_nxt  = 1'b0;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_any),
    .q   (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_br),
    .q   (FlushCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_lduse_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_lw),
    .q   (LdUseCnt)
  );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: two instances (forwarding on / off) share
// stimulus; a rule-level model queues expectations, a negedge monitor compares.
module tb_hazard_unit_mc;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf, sd, se, sm, fd, fe, fw, be;
    longint     cs, cf, cl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, DmemReqM, DmemReadyM;

  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic       a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_be;
  logic       b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_be;
  logic [3:0] a_cs, a_cf, a_cl;
  logic [7:0] b_cs, b_cf, b_cl;

  int p_fwd[2] = '{1, 0};
  int p_mw[2]  = '{4, 3};
  int p_cw[2]  = '{4, 8};

  int     m_run[2];
  bit     m_err[2];
  longint m_cs[2], m_cf[2], m_cl[2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .FWD_EN(1), .MAX_WAIT(4), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE),
    .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM), .ForwardAE(a_fa), .ForwardBE(a_fb),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm), .FlushD(a_fd),
    .FlushE(a_fe), .FlushW(a_fw), .BusErr(a_be), .StallCnt(a_cs), .FlushCnt(a_cf),
    .LdUseCnt(a_cl));

  hazard_unit_mc #(.REG_AW(5), .FWD_EN(0), .MAX_WAIT(3), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE),
    .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM), .ForwardAE(b_fa), .ForwardBE(b_fb),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm), .FlushD(b_fd),
    .FlushE(b_fe), .FlushW(b_fw), .BusErr(b_be), .StallCnt(b_cs), .FlushCnt(b_cf),
    .LdUseCnt(b_cl));

  function automatic logic [1:0] src_fwd(input logic [4:0] src);
    if (RegWriteM && RdM != 5'd0 && RdM == src) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit writer_hit(input logic [4:0] src);
    return (src != 5'd0) && ((RegWriteE && RdE == src) || (RegWriteM && RdM == src));
  endfunction

  function automatic bit lw_now();
    return ResultSrcEb0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic bit ld_stall_now(input int k);
    return lw_now() || (p_fwd[k] == 0 && (writer_hit(Rs1D) || writer_hit(Rs2D)));
  endfunction

  function automatic bit dw_now(input int k);
    return (DmemReqM && !DmemReadyM) || m_err[k];
  endfunction

  function automatic exp_t model_out(input int k);
    exp_t e;
    bit   ls, dw;
    ls   = ld_stall_now(k);
    dw   = dw_now(k);
    e.fa = (p_fwd[k] != 0) ? src_fwd(Rs1E) : 2'b00;
    e.fb = (p_fwd[k] != 0) ? src_fwd(Rs2E) : 2'b00;
    e.sf = ls || dw;
    e.sd = ls || dw;
    e.se = dw;
    e.sm = dw;
    e.fw = dw;
    e.fd = PCSrcE && !dw;
    e.fe = (PCSrcE || ls) && !dw;
    e.be = m_err[k];
    e.cs = m_cs[k];
    e.cf = m_cf[k];
    e.cl = m_cl[k];
    return e;
  endfunction

  function automatic longint sat_inc(input longint v, input int w);
    longint mx;
    mx = (64'sd1 <<< w) - 64'sd1;
    return (v < mx) ? v + 64'sd1 : mx;
  endfunction

  task automatic model_edge(input int k);
    bit ls, dw;
    if (rst) begin
      m_run[k] = 0;
      m_err[k] = 1'b0;
      m_cs[k]  = 0;
      m_cf[k]  = 0;
      m_cl[k]  = 0;
    end else begin
      ls = ld_stall_now(k);
      dw = dw_now(k);
      if (ls || dw)       m_cs[k] = sat_inc(m_cs[k], p_cw[k]);
      if (PCSrcE && !dw)  m_cf[k] = sat_inc(m_cf[k], p_cw[k]);
      if (lw_now())       m_cl[k] = sat_inc(m_cl[k], p_cw[k]);
      if (!m_err[k]) begin
        if (DmemReqM && !DmemReadyM) begin
          m_run[k]++;
          if (m_run[k] >= p_mw[k]) m_err[k] = 1'b1;
        end else begin
          m_run[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: queue expectations for the held inputs, then advance the model on the edge.
  task automatic step();
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic clear_in();
    rst = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, DmemReqM, DmemReadyM} = '0;
  endtask

  // Monitor: compare every DUT output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("a_fwdA", 64'(a_fa), 64'(e.fa));   chk("a_fwdB", 64'(a_fb), 64'(e.fb));
        chk("a_stallF", 64'(a_sf), 64'(e.sf)); chk("a_stallD", 64'(a_sd), 64'(e.sd));
        chk("a_stallE", 64'(a_se), 64'(e.se)); chk("a_stallM", 64'(a_sm), 64'(e.sm));
        chk("a_flushD", 64'(a_fd), 64'(e.fd)); chk("a_flushE", 64'(a_fe), 64'(e.fe));
        chk("a_flushW", 64'(a_fw), 64'(e.fw)); chk("a_buserr", 64'(a_be), 64'(e.be));
        chk("a_stallcnt", 64'(a_cs), e.cs);    chk("a_flushcnt", 64'(a_cf), e.cf);
        chk("a_ldusecnt", 64'(a_cl), e.cl);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("b_fwdA", 64'(b_fa), 64'(e.fa));   chk("b_fwdB", 64'(b_fb), 64'(e.fb));
        chk("b_stallF", 64'(b_sf), 64'(e.sf)); chk("b_stallD", 64'(b_sd), 64'(e.sd));
        chk("b_stallE", 64'(b_se), 64'(e.se)); chk("b_stallM", 64'(b_sm), 64'(e.sm));
        chk("b_flushD", 64'(b_fd), 64'(e.fd)); chk("b_flushE", 64'(b_fe), 64'(e.fe));
        chk("b_flushW", 64'(b_fw), 64'(e.fw)); chk("b_buserr", 64'(b_be), 64'(e.be));
        chk("b_stallcnt", 64'(b_cs), e.cs);    chk("b_flushcnt", 64'(b_cf), e.cf);
        chk("b_ldusecnt", 64'(b_cl), e.cl);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_err[k] = 1'b0; m_cs[k] = 0; m_cf[k] = 0; m_cl[k] = 0;
    end
    clear_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    clear_in();
    step();

    // forwarding priority
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    step();
    RdM = 5'd0;
    step();
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    step();
    clear_in();

    // load-use, then x0 destination
    ResultSrcEb0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    step();
    RdE = 5'd0;
    step();
    clear_in();

    // branch alone, branch under dmem wait, release
    PCSrcE = 1'b1;
    step();
    DmemReqM = 1'b1;
    step();
    DmemReadyM = 1'b1;
    step();
    clear_in();

    // dmem ready after three wait cycles
    DmemReqM = 1'b1;
    repeat (3) step();
    DmemReadyM = 1'b1;
    step();
    clear_in();

    // timeout into ERR, held after request drops, then reset clears
    DmemReqM = 1'b1;
    repeat (6) step();
    DmemReqM = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    clear_in();
    step();

    // RAW without forwarding
    RdE = 5'd3; RegWriteE = 1'b1; Rs1D = 5'd3;
    step();
    clear_in();

    // saturate the narrow counters
    ResultSrcEb0 = 1'b1; RdE = 5'd2; Rs1D = 5'd2;
    repeat (20) step();
    clear_in();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 49) == 0);
      Rs1D         = 5'($urandom_range(0, 7));
      Rs2D         = 5'($urandom_range(0, 7));
      Rs1E         = 5'($urandom_range(0, 7));
      Rs2E         = 5'($urandom_range(0, 7));
      RdE          = 5'($urandom_range(0, 7));
      RdM          = 5'($urandom_range(0, 7));
      RdW          = 5'($urandom_range(0, 7));
      RegWriteE    = 1'($urandom_range(0, 1));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      ResultSrcEb0 = ($urandom_range(0, 3) == 0);
      PCSrcE       = !ResultSrcEb0 && ($urandom_range(0, 4) == 0);
      DmemReqM     = 1'($urandom_range(0, 1));
      DmemReadyM   = ($urandom_range(0, 2) == 0);
      step();
    end
    clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
